// File: rtl/apple2_bus_host.sv
// Apple II motherboard-side bus initiator: C7M-derived PHI1, back-to-back 6502 cycles,
// slot select decode, and single read/write commands on the shared slot data bus.
//
// state | meaning
// T0    | PHI1 high, A/nWE valid for the cycle, previous command's response out
// T1    | PHI1 high
// T2    | PHI1 high
// T2L   | PHI1 high, extra C7M of a long cycle
// T3    | PHI0 high, selects asserted
// T4    | PHI0 high, write data driven
// T5    | PHI0 high
// T6    | PHI0 high, cmd_ready, cycle ends at the next edge
module apple2_bus_host #(
    parameter int          SLOT      = 7,
    parameter logic [15:0] IDLE_ADDR = 16'h0000,
    parameter bit          LONG_EN   = 1'b1
) (
    input  logic        C7M,
    input  logic        nRES,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        PHI1,
    output logic [15:0] A,
    output logic        nWE,
    inout  wire  [7:0]  D,
    output logic        nDEVSEL,
    output logic        nIOSEL,
    output logic        nIOSTRB
);

    typedef enum logic [2:0] {T0, T1, T2, T2L, T3, T4, T5, T6} phase_t;

    localparam logic [11:0] DEV_PAGE = 12'hC08 + 12'(SLOT);
    localparam logic [7:0]  IO_PAGE  = 8'hC0 + 8'(SLOT);

    phase_t      state;
    phase_t      state_nxt;
    logic        phi1_nxt;
    logic [6:0]  cyc_cnt;
    logic        cur_cmd;
    logic        cur_wr;
    logic [7:0]  cur_wdata;
    logic        d_oe;
    logic        cycle_end;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        cycle_end = 1'b0;
        case (state)
            T0:  state_nxt = T1;
            T1:  state_nxt = T2;
            T2:  state_nxt = (LONG_EN && cyc_cnt == 7'd64) ? T2L : T3;
            T2L: state_nxt = T3;
            T3:  state_nxt = T4;
            T4:  state_nxt = T5;
            T5:  state_nxt = T6;
            T6: begin
                state_nxt = T0;
                cmd_ready = 1'b1;
                cycle_end = 1'b1;
            end
            default: state_nxt = T0;
        endcase
        phi1_nxt = (state_nxt == T0) || (state_nxt == T1) ||
                   (state_nxt == T2) || (state_nxt == T2L);
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            state     <= T0;
            PHI1      <= 1'b1;
            cyc_cnt   <= 7'd0;
            cur_cmd   <= 1'b0;
            cur_wr    <= 1'b0;
            cur_wdata <= 8'h00;
            A         <= IDLE_ADDR;
            nWE       <= 1'b1;
            nDEVSEL   <= 1'b1;
            nIOSEL    <= 1'b1;
            nIOSTRB   <= 1'b1;
            d_oe      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            PHI1      <= phi1_nxt;
            rsp_valid <= 1'b0;
            if (cycle_end) begin
                cyc_cnt <= (cyc_cnt == 7'd64) ? 7'd0 : cyc_cnt + 7'd1;
                // The ending cycle's response and the newly accepted command share this edge.
                if (cur_cmd) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= cur_wr ? 8'h00 : D;
                end
                cur_cmd   <= cmd_valid;
                cur_wr    <= cmd_valid & cmd_wr;
                cur_wdata <= cmd_wdata;
                A         <= cmd_valid ? cmd_addr : IDLE_ADDR;
                nWE       <= ~(cmd_valid & cmd_wr);
                nDEVSEL   <= 1'b1;
                nIOSEL    <= 1'b1;
                nIOSTRB   <= 1'b1;
                d_oe      <= 1'b0;
            end
            if (state_nxt == T3 && state != T3) begin
                nDEVSEL <= ~(A[15:4] == DEV_PAGE);
                nIOSEL  <= ~(A[15:8] == IO_PAGE);
                nIOSTRB <= ~(A[15:11] == 5'b11001);
            end
            if (state_nxt == T4 && state != T4) begin
                d_oe <= cur_wr;
            end
        end
    end

    assign D = d_oe ? cur_wdata : {8{1'bz}};

endmodule

// File: tb/tb_apple2_bus_host.sv
// Scoreboarded bench for apple2_bus_host: random commands against a slot-level card model,
// with a cycle monitor that checks phase lengths, selects, data bus and responses.
module tb_apple2_bus_host;

    localparam int          SLOT = 7;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        C7M = 1'b0;
    logic        nRES = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic        cmd_wr = 1'b0;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        PHI1;
    logic [15:0] A;
    logic        nWE;
    logic        nDEVSEL;
    logic        nIOSEL;
    logic        nIOSTRB;
    tri1  [7:0]  D;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_q[$];
    bit          nv = 1'b0;
    logic [15:0] n_addr;
    logic        n_wr;
    logic [7:0]  n_wdata;

    apple2_bus_host #(.SLOT(SLOT), .IDLE_ADDR(IDLE), .LONG_EN(1'b1)) dut (
        .C7M(C7M), .nRES(nRES),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .PHI1(PHI1), .A(A), .nWE(nWE), .D(D),
        .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB)
    );

    always #5 C7M = ~C7M;

    function automatic logic [7:0] card_val(input logic [15:0] a);
        if (a == 16'hC700) return 8'hA9;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    // Card answers any read while PHI0 is high; D floats high (pull-up) otherwise.
    assign D = (nRES && !PHI1 && nWE) ? card_val(A) : 8'bz;

    function automatic bit in_dev(input logic [15:0] a);
        int lo = 16'hC080 + SLOT * 16;
        return (int'(a) >= lo) && (int'(a) <= lo + 15);
    endfunction

    function automatic bit in_io(input logic [15:0] a);
        int lo = 16'hC000 + SLOT * 256;
        return (int'(a) >= lo) && (int'(a) <= lo + 255);
    endfunction

    function automatic bit in_strb(input logic [15:0] a);
        return (a >= 16'hC800) && (a <= 16'hCFFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit          prev_phi1 = 1'b1;
    bit          prev_cmd = 1'b0;
    int          phi1_len = 0;
    int          phi0_len = 0;
    int          cyc_k = 0;
    logic [15:0] c_addr = 16'h0000;
    logic        c_wr = 1'b0;
    logic [7:0]  c_wdata = 8'h00;
    bit          c_cmd = 1'b0;

    always @(negedge C7M) begin
        if (!nRES) begin
            prev_phi1 = 1'b1;
            prev_cmd  = 1'b0;
            phi1_len  = 0;
            phi0_len  = 0;
            cyc_k     = 0;
            c_addr    = IDLE;
            c_wr      = 1'b0;
            c_cmd     = 1'b0;
        end else begin
            if (!prev_phi1 && PHI1) begin
                check("phi0_len", phi0_len, 4);
                prev_cmd = c_cmd;
                if (nv) begin
                    c_addr = n_addr; c_wr = n_wr; c_wdata = n_wdata; c_cmd = 1'b1; nv = 1'b0;
                end else begin
                    c_addr = IDLE; c_wr = 1'b0; c_cmd = 1'b0;
                end
                cyc_k++;
                phi1_len = 0;
                phi0_len = 0;
            end
            if (PHI1) begin
                phi1_len++;
                check("phi1_devsel", nDEVSEL, 1);
                check("phi1_iosel", nIOSEL, 1);
                check("phi1_iostrb", nIOSTRB, 1);
                check("phi1_d_float", D, 8'hFF);
                check("phi1_cmd_ready", cmd_ready, 0);
                if (phi1_len == 1) begin
                    check("rsp_valid_t0", rsp_valid, prev_cmd);
                    if (rsp_valid) begin
                        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                        else check("rsp_rdata", rsp_rdata, exp_q.pop_front());
                    end
                end else begin
                    check("rsp_valid_idle", rsp_valid, 0);
                end
            end else begin
                if (prev_phi1) check("phi1_len", phi1_len, ((cyc_k % 65) == 64) ? 4 : 3);
                phi0_len++;
                check("ndevsel", nDEVSEL, !in_dev(c_addr));
                check("niosel", nIOSEL, !in_io(c_addr));
                check("niostrb", nIOSTRB, !in_strb(c_addr));
                check("cmd_ready", cmd_ready, phi0_len == 4);
                check("rsp_valid_phi0", rsp_valid, 0);
                if (c_wr) check("d_write", D, (phi0_len == 1) ? 8'hFF : c_wdata);
                else      check("d_read", D, card_val(c_addr));
            end
            check("addr", A, c_addr);
            check("nwe", nWE, !c_wr);
            prev_phi1 = PHI1;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [15:0] a, input logic wr, input logic [7:0] wd);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_wr = wr; cmd_wdata = wd;
        for (int i = 0; i < 9 && !ok; i++) begin
            @(negedge C7M);
            if (cmd_ready) begin
                ok = 1'b1;
                exp_q.push_back(wr ? 8'h00 : card_val(a));
                n_addr = a; n_wr = wr; n_wdata = wd; nv = 1'b1;
            end
        end
        check("accept_latency", ok, 1);
        if (ok) @(posedge C7M);
        #1 cmd_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return 16'hC080 + 16'(SLOT * 16) + 16'($urandom_range(0, 15));
            1: return {8'hC0 + 8'(SLOT), 8'($urandom_range(0, 255))};
            2: return 16'hC800 + 16'($urandom_range(0, 16'h7FF));
            3: return {8'hC0, 8'($urandom_range(0, 255))};
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        repeat (3) @(posedge C7M);
        #1;
        check("rst_phi1", PHI1, 1);
        check("rst_addr", A, IDLE);
        check("rst_nwe", nWE, 1);
        check("rst_sel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
        check("rst_d", D, 8'hFF);
        check("rst_ready", cmd_ready, 0);
        check("rst_rsp", {rsp_valid, rsp_rdata}, 9'h000);
        @(posedge C7M);
        #2 nRES = 1'b1;

        // idle run spanning at least one long cycle
        repeat (470) @(posedge C7M);
        #1;

        issue(16'hC0F3, 1'b1, 8'h5A);
        issue(16'hC700, 1'b0, 8'h00);
        repeat (10) @(posedge C7M);
        #1;
        // back-to-back: cmd_valid never drops between these
        issue(16'hCFFF, 1'b0, 8'h00);
        issue(16'hC800, 1'b0, 8'h00);
        issue(16'hC0E0, 1'b0, 8'h00);

        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 20)) @(posedge C7M);
                #1;
            end
            issue(rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)));
        end

        // reset in the middle of a write's data phase
        issue(16'hC0F5, 1'b1, 8'h33);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge C7M);
            if (!PHI1) got = 1'b1;
        end
        check("reach_phi0", got, 1);
        @(posedge C7M);
        #1 check("abort_d_before", D, 8'h33);
        #1 nRES = 1'b0;
        #1;
        check("abort_d", D, 8'hFF);
        check("abort_sel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
        check("abort_phi1", PHI1, 1);
        check("abort_rsp", {rsp_valid, rsp_rdata}, 9'h000);
        exp_q.delete();
        nv = 1'b0;
        repeat (3) @(posedge C7M);
        #2 nRES = 1'b1;

        for (int n = 0; n < 12; n++) begin
            issue(rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)));
        end

        repeat (30) @(posedge C7M);
        #1 check("rsp_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
